// File: rtl/cpu_types_pkg.sv
// Shared CPU types: word/register types and the write-back select encoding.
// Imported by the MEM stage and its MEM/WB register.
package cpu_types_pkg;

    localparam int WORD_BITS = 32;
    localparam int REG_BITS  = 5;

    typedef logic [WORD_BITS-1:0] word_t;
    typedef logic [REG_BITS-1:0]  regbits_t;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_MEM = 2'd1,
        WB_NPC = 2'd2,
        WB_EXT = 2'd3
    } wb_sel_t;

endpackage

// File: rtl/mem_stage_memwb_reg.sv
// MEM/WB pipeline register with bubble insertion and a sticky halt flag.
// Ports: clk/rst, load/bubble control, next write-back fields in, registered fields out.
module memwb_reg
    import cpu_types_pkg::*;
#(
    parameter int WORD_W = 32,
    parameter int REG_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              bubble,
    input  logic [WORD_W-1:0] wdat,
    input  logic [REG_W-1:0]  wsel,
    input  logic              regw,
    input  logic              halt,
    output logic [WORD_W-1:0] wb_wdat,
    output logic [REG_W-1:0]  wb_wsel,
    output logic              wb_regw,
    output logic              wb_halt
);

    // Neither load nor bubble: hold (used once the stage has halted).
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_wdat <= '0;
            wb_wsel <= '0;
            wb_regw <= 1'b0;
            wb_halt <= 1'b0;
        end else if (bubble) begin
            wb_wdat <= '0;
            wb_wsel <= '0;
            wb_regw <= 1'b0;
        end else if (load) begin
            wb_wdat <= wdat;
            wb_wsel <= wsel;
            wb_regw <= regw;
            wb_halt <= wb_halt | halt;
        end
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: data-cache handshake, stall generation, write-back select, MEM/WB register.
// Ports: EX/MEM fields in, dmem request/response, mem_stall, MEM/WB outputs. Option: LL_SC_EN.
module mem_stage
    import cpu_types_pkg::*;
#(
    parameter int WORD_W = 32,
    parameter int REG_W  = 5
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              DRen_i,
    input  logic              DWen_i,
    input  logic [WORD_W-1:0] alu_out_i,
    input  logic [WORD_W-1:0] rdat2_i,
    input  logic [WORD_W-1:0] npc_i,
    input  logic [WORD_W-1:0] extout_i,
    input  logic [1:0]        wb_sel_i,
    input  logic              RegW_i,
    input  logic [REG_W-1:0]  RegDest_i,
    input  logic              halt_i,
`ifdef LL_SC_EN
    input  logic              ll_i,
    input  logic              sc_i,
    input  logic              ccinv,
    input  logic [WORD_W-1:0] ccsnoopaddr,
`endif
    input  logic              dhit,
    input  logic [WORD_W-1:0] dmemload,
    output logic              dmemREN,
    output logic              dmemWEN,
    output logic [WORD_W-1:0] dmemaddr,
    output logic [WORD_W-1:0] dmemstore,
    output logic              mem_stall,
    output logic [WORD_W-1:0] wdat_o,
    output logic [REG_W-1:0]  wsel_o,
    output logic              RegW_o,
    output logic              halt_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t state, state_next;

    logic              halted;
    logic              req;
    logic              sc_fail;
    logic              load;
    logic              bubble;
    logic [WORD_W-1:0] wb_data;

    assign halted = (state == HALTED);

`ifdef LL_SC_EN
    logic              link_valid;
    logic [WORD_W-1:0] link_addr;
    logic              link_hit;
    logic              ll_done;
    logic              sc_done;
    logic              st_done;
    logic              inv_hit;

    assign link_hit = link_valid && (link_addr == alu_out_i);
    // A failing SC never reaches the cache; it just writes 0 to rt.
    assign sc_fail  = sc_i & ~link_hit;
    assign ll_done  = ~halted & ll_i & DRen_i & ~DWen_i & dhit;
    assign sc_done  = ~halted & sc_i & ~sc_fail & DWen_i & dhit;
    assign st_done  = ~halted & ~sc_i & DWen_i & dhit
                    & (alu_out_i == link_addr);
    // Snoop matches the current link or the one being set this cycle.
    assign inv_hit  = ccinv
                    & ((ccsnoopaddr == link_addr)
                    | (ll_done & (ccsnoopaddr == alu_out_i)));

    always_ff @(posedge CLK) begin
        if (RST) begin
            link_valid <= 1'b0;
            link_addr  <= '0;
        end else begin
            if (ll_done) begin
                link_addr  <= alu_out_i;
                link_valid <= 1'b1;
            end
            if (sc_done || st_done) begin
                link_valid <= 1'b0;
            end
            if (inv_hit) begin
                link_valid <= 1'b0;
            end
        end
    end
`else
    assign sc_fail = 1'b0;
`endif

    assign req = (DRen_i | DWen_i) & ~sc_fail;

    // State register
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE, WAIT: begin
                if (halt_i && !mem_stall) begin
                    state_next = HALTED;
                end else if (mem_stall) begin
                    state_next = WAIT;
                end else begin
                    state_next = IDLE;
                end
            end
            HALTED:  state_next = HALTED;
            default: state_next = IDLE;
        endcase
    end

    // Outputs: cache request, stall, MEM/WB control
    always_comb begin
        dmemREN   = 1'b0;
        dmemWEN   = 1'b0;
        mem_stall = 1'b0;
        load      = 1'b0;
        bubble    = 1'b0;
        if (!halted) begin
            // Write wins if both requests are (illegally) raised.
            dmemREN   = DRen_i & ~DWen_i & ~sc_fail;
            dmemWEN   = DWen_i & ~sc_fail;
            mem_stall = req & ~dhit;
            load      = ~mem_stall;
            bubble    = mem_stall;
        end
    end

    assign dmemaddr  = alu_out_i;
    assign dmemstore = rdat2_i;

    always_comb begin
        wb_data = alu_out_i;
        unique case (wb_sel_t'(wb_sel_i))
            WB_ALU: wb_data = alu_out_i;
            WB_MEM: wb_data = dmemload;
            WB_NPC: wb_data = npc_i;
            WB_EXT: wb_data = extout_i;
            default: wb_data = alu_out_i;
        endcase
`ifdef LL_SC_EN
        if (sc_i) begin
            wb_data    = '0;
            wb_data[0] = ~sc_fail;
        end
`endif
    end

    memwb_reg #(
        .WORD_W(WORD_W),
        .REG_W (REG_W)
    ) u_memwb (
        .clk    (CLK),
        .rst    (RST),
        .load   (load),
        .bubble (bubble),
        .wdat   (wb_data),
        .wsel   (RegDest_i),
        .regw   (RegW_i),
        .halt   (halt_i),
        .wb_wdat(wdat_o),
        .wb_wsel(wsel_o),
        .wb_regw(RegW_o),
        .wb_halt(halt_o)
    );

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: random and directed instructions against a transaction model.
// Exercises LL/SC too when built with LL_SC_EN.
module tb_mem_stage;

    logic        CLK = 1'b0;
    logic        RST;
    logic        DRen_i, DWen_i;
    logic [31:0] alu_out_i, rdat2_i, npc_i, extout_i;
    logic [1:0]  wb_sel_i;
    logic        RegW_i;
    logic [4:0]  RegDest_i;
    logic        halt_i;
    logic        ll_i, sc_i, ccinv;
    logic [31:0] ccsnoopaddr;
    logic        dhit;
    logic [31:0] dmemload;
    logic        dmemREN, dmemWEN, mem_stall;
    logic [31:0] dmemaddr, dmemstore, wdat_o;
    logic [4:0]  wsel_o;
    logic        RegW_o, halt_o;

    int total = 0;
    int bad   = 0;

    always #5 CLK = ~CLK;

    mem_stage dut (
        .CLK        (CLK),
        .RST        (RST),
        .DRen_i     (DRen_i),
        .DWen_i     (DWen_i),
        .alu_out_i  (alu_out_i),
        .rdat2_i    (rdat2_i),
        .npc_i      (npc_i),
        .extout_i   (extout_i),
        .wb_sel_i   (wb_sel_i),
        .RegW_i     (RegW_i),
        .RegDest_i  (RegDest_i),
        .halt_i     (halt_i),
`ifdef LL_SC_EN
        .ll_i       (ll_i),
        .sc_i       (sc_i),
        .ccinv      (ccinv),
        .ccsnoopaddr(ccsnoopaddr),
`endif
        .dhit       (dhit),
        .dmemload   (dmemload),
        .dmemREN    (dmemREN),
        .dmemWEN    (dmemWEN),
        .dmemaddr   (dmemaddr),
        .dmemstore  (dmemstore),
        .mem_stall  (mem_stall),
        .wdat_o     (wdat_o),
        .wsel_o     (wsel_o),
        .RegW_o     (RegW_o),
        .halt_o     (halt_o)
    );

    task automatic quiet();
        DRen_i = 0; DWen_i = 0; halt_i = 0; dhit = 0;
        ll_i = 0; sc_i = 0; ccinv = 0; ccsnoopaddr = 0;
        RegW_i = 0; RegDest_i = 0; wb_sel_i = 0;
        alu_out_i = 0; rdat2_i = 0; npc_i = 0; extout_i = 0;
        dmemload = 0;
    endtask

    // One instruction held in EX/MEM until the cache answers after lat cycles.
    task automatic run_op(input logic dr, input logic dw,
                          input logic [31:0] addr, input logic [31:0] sd,
                          input logic [31:0] np, input logic [31:0] ex,
                          input logic [31:0] ld, input logic [1:0] sel,
                          input logic rw, input logic [4:0] dst,
                          input int lat, input string nm);
        logic [31:0] res;
        logic        exp_stall;
        case (sel)
            2'd0: res = addr;
            2'd1: res = ld;
            2'd2: res = np;
            default: res = ex;
        endcase
        for (int c = 0; c <= lat; c++) begin
            DRen_i = dr; DWen_i = dw; alu_out_i = addr; rdat2_i = sd;
            npc_i = np; extout_i = ex; wb_sel_i = sel; RegW_i = rw;
            RegDest_i = dst; halt_i = 0;
            dhit = (c == lat);
            dmemload = (c == lat) ? ld : $urandom;
            exp_stall = (dr | dw) && (c < lat);
            @(negedge CLK);
            total++;
            if (mem_stall !== exp_stall) begin
                bad++;
                $display("FAIL %s stall c=%0d got=%b exp=%b", nm, c, mem_stall, exp_stall);
            end
            total++;
            if ({dmemREN, dmemWEN} !== {dr & ~dw, dw}) begin
                bad++;
                $display("FAIL %s req c=%0d got=%b%b exp=%b%b", nm, c,
                         dmemREN, dmemWEN, dr & ~dw, dw);
            end
            total++;
            if (dmemaddr !== addr || dmemstore !== sd) begin
                bad++;
                $display("FAIL %s addr/store got=%h/%h exp=%h/%h", nm,
                         dmemaddr, dmemstore, addr, sd);
            end
            @(posedge CLK); #1;
            total++;
            if (c < lat) begin
                if ({RegW_o, wsel_o, wdat_o} !== {1'b0, 5'd0, 32'd0}) begin
                    bad++;
                    $display("FAIL %s bubble c=%0d got=%b/%0d/%h exp=0/0/0", nm, c,
                             RegW_o, wsel_o, wdat_o);
                end
            end else begin
                if ({RegW_o, wsel_o, wdat_o} !== {rw, dst, res}) begin
                    bad++;
                    $display("FAIL %s wb got=%b/%0d/%h exp=%b/%0d/%h", nm,
                             RegW_o, wsel_o, wdat_o, rw, dst, res);
                end
            end
            total++;
            if (halt_o !== 1'b0) begin
                bad++;
                $display("FAIL %s halt got=%b exp=0", nm, halt_o);
            end
        end
        quiet();
    endtask

    task automatic test_reset();
        RST = 1;
        quiet();
        DRen_i = 1; alu_out_i = 32'h55; RegW_i = 1; RegDest_i = 5'd3;
        repeat (2) @(posedge CLK);
        #1;
        total++;
        if ({RegW_o, wsel_o, wdat_o, halt_o} !== 39'd0) begin
            bad++;
            $display("FAIL reset got=%b/%0d/%h/%b exp=0/0/0/0", RegW_o, wsel_o, wdat_o, halt_o);
        end
        RST = 0;
        quiet();
        @(posedge CLK); #1;
    endtask

    task automatic test_load();
        run_op(1, 0, 32'h100, 32'h0, 32'h4, 32'h0, 32'hDEADBEEF,
               2'b01, 1, 5'd8, 3, "load");
    endtask

    task automatic test_store_hit();
        run_op(0, 1, 32'h200, 32'h1234, 32'h8, 32'h0, 32'h0,
               2'b00, 0, 5'd0, 0, "store_hit");
    endtask

    task automatic test_jal();
        run_op(0, 0, 32'h0, 32'h0, 32'h44, 32'h0, 32'h0,
               2'b10, 1, 5'd31, 0, "jal");
        run_op(0, 0, 32'h7, 32'h0, 32'h0, 32'hABCD0000, 32'h0,
               2'b11, 1, 5'd0, 0, "lui_r0");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            run_op(1, 0, 32'h400 + i * 4, 32'h0, 32'h0, 32'h0, 32'hC0DE0000 + i,
                   2'b01, 1, 5'(i + 1), 0, "b2b");
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            int          kind;
            logic        dr, dw;
            int          lat;
            kind = $urandom_range(0, 2);
            dr = (kind == 1);
            dw = (kind == 2);
            lat = (kind == 0) ? 0 : $urandom_range(0, 3);
            run_op(dr, dw, $urandom, $urandom, $urandom, $urandom, $urandom,
                   2'($urandom_range(0, 3)), 1'($urandom), 5'($urandom),
                   lat, "rand");
        end
    endtask

    task automatic test_rst_in_wait();
        DRen_i = 1; alu_out_i = 32'h600; wb_sel_i = 2'b01;
        RegW_i = 1; RegDest_i = 5'd9; dhit = 0;
        repeat (2) @(posedge CLK);
        #1;
        RST = 1;
        @(posedge CLK); #1;
        total++;
        if ({RegW_o, wsel_o, wdat_o} !== 38'd0) begin
            bad++;
            $display("FAIL rst_wait got=%b/%0d/%h exp=0/0/0", RegW_o, wsel_o, wdat_o);
        end
        RST = 0;
        quiet();
        run_op(0, 0, 32'h77, 32'h0, 32'h0, 32'h0, 32'h0,
               2'b00, 1, 5'd2, 0, "after_rst");
        run_op(1, 0, 32'h604, 32'h0, 32'h0, 32'h0, 32'h12345678,
               2'b01, 1, 5'd4, 1, "after_rst_ld");
    endtask

`ifdef LL_SC_EN
    task automatic sc_op(input logic hit, input logic [31:0] exp, input string nm);
        DWen_i = 1; sc_i = 1; alu_out_i = 32'h300; rdat2_i = 32'h99;
        RegW_i = 1; RegDest_i = 5'd10; dhit = hit;
        @(negedge CLK);
        total++;
        if ({dmemWEN, mem_stall} !== {hit, 1'b0}) begin
            bad++;
            $display("FAIL %s wen/stall got=%b%b exp=%b0", nm, dmemWEN, mem_stall, hit);
        end
        @(posedge CLK); #1;
        total++;
        if ({RegW_o, wsel_o, wdat_o} !== {1'b1, 5'd10, exp}) begin
            bad++;
            $display("FAIL %s wb got=%b/%0d/%h exp=1/10/%h", nm, RegW_o, wsel_o, wdat_o, exp);
        end
        quiet();
    endtask

    task automatic test_llsc();
        ll_i = 1;
        run_op(1, 0, 32'h300, 32'h0, 32'h0, 32'h0, 32'h5, 2'b01, 1, 5'd10, 0, "ll1");
        ccinv = 1; ccsnoopaddr = 32'h300;
        @(posedge CLK); #1;
        quiet();
        sc_op(1, 32'd0, "sc_inv");
        ll_i = 1;
        run_op(1, 0, 32'h300, 32'h0, 32'h0, 32'h0, 32'h5, 2'b01, 1, 5'd10, 0, "ll2");
        sc_op(1, 32'd1, "sc_ok");
        sc_op(1, 32'd0, "sc_again");
    endtask
`endif

    task automatic test_halt();
        alu_out_i = 32'hAA; wb_sel_i = 2'b00; RegW_i = 1; RegDest_i = 5'd5;
        halt_i = 1;
        @(posedge CLK); #1;
        total++;
        if ({halt_o, RegW_o, wsel_o, wdat_o} !== {1'b1, 1'b1, 5'd5, 32'hAA}) begin
            bad++;
            $display("FAIL halt got=%b/%b/%0d/%h exp=1/1/5/aa", halt_o, RegW_o, wsel_o, wdat_o);
        end
        quiet();
        DRen_i = 1; alu_out_i = 32'h1000; RegW_i = 1; RegDest_i = 5'd7; dhit = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            total++;
            if ({dmemREN, dmemWEN, mem_stall} !== 3'b000) begin
                bad++;
                $display("FAIL halted_req got=%b%b%b exp=000", dmemREN, dmemWEN, mem_stall);
            end
            dhit = (i == 1);
            @(posedge CLK); #1;
            total++;
            if ({halt_o, RegW_o, wsel_o, wdat_o} !== {1'b1, 1'b1, 5'd5, 32'hAA}) begin
                bad++;
                $display("FAIL halted_hold got=%b/%b/%0d/%h exp=1/1/5/aa",
                         halt_o, RegW_o, wsel_o, wdat_o);
            end
        end
        RST = 1;
        @(posedge CLK); #1;
        RST = 0;
        quiet();
        total++;
        if ({halt_o, RegW_o, wdat_o} !== 34'd0) begin
            bad++;
            $display("FAIL halt_rst got=%b/%b/%h exp=0/0/0", halt_o, RegW_o, wdat_o);
        end
        run_op(1, 0, 32'h20, 32'h0, 32'h0, 32'h0, 32'hFEED, 2'b01, 1, 5'd6, 2, "post_halt");
    endtask

    initial begin
        quiet();
        test_reset();
        test_load();
        test_store_hit();
        test_jal();
        test_back_to_back();
        test_random();
        test_rst_in_wait();
`ifdef LL_SC_EN
        test_llsc();
`endif
        test_halt();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
